// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: skid-stage state encoding, default NOP bundle
// and field widths of the ID/EX, EX/MEM and MEM/WB stage bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_REG_ID_W   = 4;
  localparam int unsigned PIPE_DATA_W     = 16;
  localparam int unsigned PIPE_IDEX_CTRL_W  = 8;
  localparam int unsigned PIPE_EXMEM_CTRL_W = 4;
  localparam int unsigned PIPE_MEMWB_CTRL_W = 2;

  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_DEFAULT = '0;

  typedef struct packed {
    logic [PIPE_IDEX_CTRL_W-1:0] ctrl;
    logic [PIPE_REG_ID_W-1:0]    rs1;
    logic [PIPE_REG_ID_W-1:0]    rs2;
    logic [PIPE_REG_ID_W-1:0]    rd;
    logic [PIPE_DATA_W-1:0]      op_a;
    logic [PIPE_DATA_W-1:0]      op_b;
  } pipe_idex_t;

  typedef struct packed {
    logic [PIPE_EXMEM_CTRL_W-1:0] ctrl;
    logic [PIPE_REG_ID_W-1:0]     rd;
    logic [PIPE_DATA_W-1:0]       alu_res;
    logic [PIPE_DATA_W-1:0]       st_data;
  } pipe_exmem_t;

  typedef struct packed {
    logic [PIPE_MEMWB_CTRL_W-1:0] ctrl;
    logic [PIPE_REG_ID_W-1:0]     rd;
    logic [PIPE_DATA_W-1:0]       wb_data;
  } pipe_memwb_t;

  // State encoding is chosen so that it equals the number of held entries.
  function automatic logic [1:0] pipe_occupancy(input pipe_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with a two-entry skid buffer and flush-to-NOP.
// Optional stall/flush performance counters when PIPE_PERF_CNT_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = PIPE_DATA_W,
  parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
  end

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occ_q, occ_d;
  logic             load, unload;

  // Next-state and datapath; flush overrides any handshake on the same edge.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    load    = in_valid & in_ready_q;
    unload  = out_valid_q & out_ready;
    if (flush) begin
      state_d = PIPE_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        PIPE_EMPTY: begin
          if (load) begin
            main_d  = in_data;
            state_d = PIPE_BUSY;
          end
        end
        PIPE_BUSY: begin
          if (load && !unload) begin
            skid_d  = in_data;
            state_d = PIPE_FULL;
          end else if (!load && unload) begin
            state_d = PIPE_EMPTY;
          end else if (load && unload) begin
            main_d  = in_data;
          end
        end
        PIPE_FULL: begin
          if (unload) begin
            main_d  = skid_q;
            state_d = PIPE_BUSY;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != PIPE_FULL);
    out_valid_d = (state_d != PIPE_EMPTY);
    occ_d       = pipe_occupancy(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PIPE_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_en, flush_en;

  assign stall_en = out_valid_q & ~out_ready;
  assign flush_en = flush & (occ_q != 2'd0);

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (flush_en),
    .cnt_o (flush_cnt)
  );
`endif

endmodule
